// File: rtl/game_status_sequencer_pkg.sv
// Shared status codes, message codes and sequencer state encoding.
package game_status_sequencer_pkg;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned LED_W  = 8;
  localparam int unsigned MSG_W  = 2;

  // Game controller status codes
  localparam logic [CODE_W-1:0] ST_AUTH      = 8'h00;
  localparam logic [CODE_W-1:0] ST_AUTH_OK   = 8'h01;
  localparam logic [CODE_W-1:0] ST_AUTH_FAIL = 8'h02;
  localparam logic [CODE_W-1:0] ST_PLAY      = 8'h10;
  localparam logic [CODE_W-1:0] ST_TIMEOUT   = 8'h12;
  localparam logic [CODE_W-1:0] ST_WIN       = 8'h20;
  localparam logic [CODE_W-1:0] ST_WIN_END   = 8'h21;
  localparam logic [CODE_W-1:0] ST_LOSE      = 8'h30;
  localparam logic [CODE_W-1:0] ST_LOSE_END  = 8'h31;

  // Display message codes
  localparam logic [MSG_W-1:0] MSG_NONE    = 2'b00;
  localparam logic [MSG_W-1:0] MSG_DEFUSED = 2'b01;
  localparam logic [MSG_W-1:0] MSG_BOOM    = 2'b10;

  typedef enum logic [1:0] {
    SEQ_IDLE    = 2'd0,
    SEQ_SUCCESS = 2'd1,
    SEQ_BLINK   = 2'd2,
    SEQ_DONE    = 2'd3
  } seq_state_e;

  function automatic logic is_succ_code(input logic [CODE_W-1:0] s);
    return s == ST_WIN;
  endfunction

  function automatic logic is_over_code(input logic [CODE_W-1:0] s);
    return (s == ST_LOSE) || (s == ST_TIMEOUT);
  endfunction

  function automatic logic is_start_code(input logic [CODE_W-1:0] s);
    return is_succ_code(s) || is_over_code(s);
  endfunction

  function automatic logic is_abort_code(input logic [CODE_W-1:0] s);
    return (s == ST_AUTH) || (s == ST_AUTH_OK);
  endfunction

endpackage

// File: rtl/game_status_sequencer_step_timer.sv
// Tick divider plus step counter; step_c is the combinational step pulse.
module game_status_sequencer_step_timer #(
  parameter int unsigned STEP_TICKS = 4,
  parameter int unsigned STEP_MAX   = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          clr,
  input  logic                                          tick,
  output logic                                          step_c,
  output logic [((STEP_MAX > 1) ? $clog2(STEP_MAX) : 1)-1:0] step_idx
);

  localparam int unsigned TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int unsigned SW = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;

  logic [TW-1:0] tick_cnt;

  // A step fires on the tick that completes a full STEP_TICKS group
  assign step_c = !clr && tick && (tick_cnt == TW'(STEP_TICKS - 1));

  // Tick divider and step index; held cleared while no animation runs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      step_idx <= '0;
    end else if (clr) begin
      tick_cnt <= '0;
      step_idx <= '0;
    end else if (tick) begin
      if (step_c) begin
        tick_cnt <= '0;
        step_idx <= step_idx + SW'(1);
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

endmodule

// File: rtl/game_status_sequencer.sv
// End-of-game LED animation sequencer driven by the controller status code.
module game_status_sequencer
  import game_status_sequencer_pkg::*;
#(
  parameter int unsigned STEP_TICKS    = 4,
  parameter int unsigned SUCCESS_STEPS = 8,
  parameter int unsigned OVER_STEPS    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] s_current,
  input  logic              tick,
  output logic [LED_W-1:0]  led,
  output logic [MSG_W-1:0]  msg,
  output logic              seq_done,
  output logic              busy
);

  localparam int unsigned STEP_MAX = (SUCCESS_STEPS > OVER_STEPS) ? SUCCESS_STEPS : OVER_STEPS;
  localparam int unsigned SW       = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;

  seq_state_e    state;
  logic          clr_c;
  logic          step_c;
  logic [SW-1:0] step_idx;

  // Counters only run while an animation is active, so the entry-cycle tick is dropped
  assign clr_c = !((state == SEQ_SUCCESS) || (state == SEQ_BLINK));

  game_status_sequencer_step_timer #(
    .STEP_TICKS (STEP_TICKS),
    .STEP_MAX   (STEP_MAX)
  ) u_step_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_c),
    .tick     (tick),
    .step_c   (step_c),
    .step_idx (step_idx)
  );

  // Sequencer FSM with registered LED, message and handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= SEQ_IDLE;
      led      <= '0;
      msg      <= MSG_NONE;
      seq_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          led      <= '0;
          msg      <= MSG_NONE;
          seq_done <= 1'b0;
          busy     <= 1'b0;
          if (is_succ_code(s_current)) begin
            state <= SEQ_SUCCESS;
            led   <= 8'h01;
            busy  <= 1'b1;
          end else if (is_over_code(s_current)) begin
            state <= SEQ_BLINK;
            led   <= 8'hFF;
            busy  <= 1'b1;
          end
        end
        SEQ_SUCCESS: begin
          if (is_abort_code(s_current)) begin
            state <= SEQ_IDLE;
            led   <= '0;
            busy  <= 1'b0;
          end else if (step_c) begin
            if (step_idx == SW'(SUCCESS_STEPS - 1)) begin
              state    <= SEQ_DONE;
              led      <= 8'hFF;
              msg      <= MSG_DEFUSED;
              seq_done <= 1'b1;
              busy     <= 1'b0;
            end else begin
              led <= {led[LED_W-2:0], led[LED_W-1]};
            end
          end
        end
        SEQ_BLINK: begin
          if (is_abort_code(s_current)) begin
            state <= SEQ_IDLE;
            led   <= '0;
            busy  <= 1'b0;
          end else if (step_c) begin
            if (step_idx == SW'(OVER_STEPS - 1)) begin
              state    <= SEQ_DONE;
              led      <= 8'h00;
              msg      <= MSG_BOOM;
              seq_done <= 1'b1;
              busy     <= 1'b0;
            end else begin
              led <= ~led;
            end
          end
        end
        SEQ_DONE: begin
          // Hold the result until the controller moves off the start codes
          if (!is_start_code(s_current)) begin
            state    <= SEQ_IDLE;
            led      <= '0;
            msg      <= MSG_NONE;
            seq_done <= 1'b0;
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

endmodule
